// File: rtl/gcd_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// GCD coprocessor arbiter (gcd_rr_arbiter / gcd_arb_tag_fifo).
package gcd_arb_pkg;

  localparam int unsigned W_DEF       = 16;
  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned TAG_DEP_DEF = 4;
  localparam int unsigned NREQ_MAX    = 8;

  localparam int unsigned TAG_W = $clog2(NREQ_DEF);
  localparam int unsigned CNT_W = $clog2(TAG_DEP_DEF) + 1;

  // Returns the first set index of req scanning upward from ptr, wrapping at
  // nreq. With no request set the pointer itself is returned.
  function automatic int unsigned rr_pick(input logic [NREQ_MAX-1:0] req,
                                          input int unsigned         ptr,
                                          input int unsigned         nreq);
    int unsigned pick;
    int unsigned idx;
    pick = ptr;
    // Walk the scan window from its far end so the nearest hit wins.
    for (int unsigned k = NREQ_MAX; k > 0; k--) begin
      if (k <= nreq) begin
        idx = (ptr + k - 1) % nreq;
        if (req[idx[$clog2(NREQ_MAX)-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gcd_arb_tag_fifo.sv
// Tag FIFO: remembers which requester owns each operand pair in flight.
// Power-of-two depth, so read/write pointers wrap naturally.
module gcd_arb_tag_fifo
  import gcd_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = TAG_W,
  parameter int unsigned DEPTH     = TAG_DEP_DEF,
  parameter int unsigned CNT_WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full    = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and count registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_rr_arbiter.sv
// Round-robin arbiter sharing one GCD coprocessor between NREQ requesters.
// A tag FIFO records the owner of every accepted operand pair; results come
// back in order, so the FIFO head selects the result's destination.
// Optional statistics counters: define GCD_ARB_STATS_EN.
module gcd_rr_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned TAG_DEP = TAG_DEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  input  logic [NREQ*W-1:0] req_bits_A,
  input  logic [NREQ*W-1:0] req_bits_B,
  output logic [NREQ-1:0]   req_rdy,
  output logic [NREQ-1:0]   resp_val,
  output logic [W-1:0]      resp_bits,
  input  logic [NREQ-1:0]   resp_rdy,
  output logic              cop_op_val,
  output logic [W-1:0]      cop_op_A,
  output logic [W-1:0]      cop_op_B,
  input  logic              cop_op_rdy,
  input  logic              cop_res_val,
  input  logic [W-1:0]      cop_res_bits,
  output logic              cop_res_rdy,
  output logic              err_orphan
`ifdef GCD_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grants,
  output logic [15:0]        stat_stall
`endif
);

  localparam int unsigned TW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TAG_DEP) + 1;

  logic [TW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]       gnt, head;
  logic [NREQ_MAX-1:0] req_pad;
  logic                any_val, fifo_full, fifo_empty, fire, pop, head_rdy;
  logic                err_orphan_q, err_orphan_d;

  gcd_arb_tag_fifo #(
    .WIDTH    (TW),
    .DEPTH    (TAG_DEP),
    .CNT_WIDTH(CW)
  ) u_tag_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fire),
    .din  (gnt),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Issue path: round-robin grant and operand mux, no added latency.
  // req_rdy is held at zero when nobody requests, since the grant index is
  // meaningless then.
  always_comb begin
    req_pad              = '0;
    req_pad[NREQ-1:0]    = req_val;
    gnt                  = TW'(rr_pick(req_pad, 32'(rr_ptr_q), NREQ));
    any_val              = |req_val;
    cop_op_val           = reset & any_val & ~fifo_full;
    fire                 = cop_op_val & cop_op_rdy;
    cop_op_A             = '0;
    cop_op_B             = '0;
    req_rdy              = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt == TW'(i)) begin
        cop_op_A   = req_bits_A[i*W +: W];
        cop_op_B   = req_bits_B[i*W +: W];
        req_rdy[i] = reset & any_val & cop_op_rdy & ~fifo_full;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (fire) rr_ptr_d = (32'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
  end

  // Return path: steer the in-order result to the FIFO head's owner.
  always_comb begin
    resp_bits = cop_res_bits;
    resp_val  = '0;
    head_rdy  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (head == TW'(i)) begin
        resp_val[i] = reset & cop_res_val & ~fifo_empty;
        head_rdy    = resp_rdy[i];
      end
    end
    cop_res_rdy  = reset & ~fifo_empty & head_rdy;
    pop          = cop_res_val & cop_res_rdy;
    err_orphan_d = err_orphan_q | (cop_res_val & fifo_empty);
  end

  // Round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign err_orphan = err_orphan_q;

`ifdef GCD_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants_q, stat_grants_d;
  logic [15:0]        stat_stall_q, stat_stall_d;

  // Saturating per-requester fire counts and stall-cycle count.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stall_d  = stat_stall_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (fire && gnt == TW'(i) && stat_grants_q[i*16 +: 16] != '1)
        stat_grants_d[i*16 +: 16] = stat_grants_q[i*16 +: 16] + 16'd1;
    end
    if (any_val && !fire && stat_stall_q != '1) stat_stall_d = stat_stall_q + 16'd1;
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// Self-checking bench for gcd_rr_arbiter: a queue-based reference model of
// the arbiter plus a simple in-order GCD coprocessor model, directed cases
// followed by a randomized phase.
`timescale 1ns/1ps
module tb_gcd_rr_arbiter;

  localparam int unsigned W       = 16;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TAG_DEP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_val, req_rdy, resp_val, resp_rdy;
  logic [NREQ*W-1:0] req_bits_A, req_bits_B;
  logic [W-1:0]      resp_bits, cop_op_A, cop_op_B, cop_res_bits;
  logic              cop_op_val, cop_op_rdy, cop_res_val, cop_res_rdy, err_orphan;
`ifdef GCD_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
  logic [15:0]        stat_stall;
`endif

  always #5 clk = ~clk;

  gcd_rr_arbiter #(.W(W), .NREQ(NREQ), .TAG_DEP(TAG_DEP)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_bits_A  (req_bits_A),
    .req_bits_B  (req_bits_B),
    .req_rdy     (req_rdy),
    .resp_val    (resp_val),
    .resp_bits   (resp_bits),
    .resp_rdy    (resp_rdy),
    .cop_op_val  (cop_op_val),
    .cop_op_A    (cop_op_A),
    .cop_op_B    (cop_op_B),
    .cop_op_rdy  (cop_op_rdy),
    .cop_res_val (cop_res_val),
    .cop_res_bits(cop_res_bits),
    .cop_res_rdy (cop_res_rdy),
    .err_orphan  (err_orphan)
`ifdef GCD_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  // Reference state
  int m_ptr;
  int m_tags[$];
  int m_cop[$];
  bit m_orphan;
  int m_grants[NREQ];
  int m_stall;
  bit cop_en, inject;
  // Observation logs
  int fire_log[$];
  int dlv_own[$];
  int dlv_val[$];
  int checks = 0;
  int failures = 0;

  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    fire_log.delete();
    dlv_own.delete();
    dlv_val.delete();
  endtask

  // One clock: check at negedge against the model, advance model at posedge.
  task automatic cycle();
    int g, h;
    bit any, full, empty, fire, pop;
    logic [NREQ-1:0] e_req_rdy, e_resp_val;
    logic e_op_val, e_res_rdy;
    logic [W-1:0] ea, eb;
    cop_res_val  = inject || (cop_en && m_cop.size() > 0);
    cop_res_bits = (m_cop.size() > 0) ? W'(m_cop[0]) : 16'hDEAD;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (cop_op_val && cop_op_rdy && req_rdy[i]) fire_log.push_back(i);
      if (resp_val[i] && resp_rdy[i]) begin
        dlv_own.push_back(i);
        dlv_val.push_back(int'(resp_bits));
      end
    end
    any   = |req_val;
    full  = (m_tags.size() == TAG_DEP);
    empty = (m_tags.size() == 0);
    g = m_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (req_val[i]) begin
        g = i;
        break;
      end
    end
    ea = req_bits_A[g*W +: W];
    eb = req_bits_B[g*W +: W];
    fire = 0;
    pop  = 0;
    if (reset) begin
      e_op_val  = any && !full;
      fire      = e_op_val && cop_op_rdy;
      e_req_rdy = fire ? (NREQ'(1) << g) : '0;
      h         = empty ? 0 : m_tags[0];
      e_resp_val = (cop_res_val && !empty) ? (NREQ'(1) << h) : '0;
      e_res_rdy = !empty && resp_rdy[h];
      pop       = cop_res_val && e_res_rdy;
      chk("cop_op_val", cop_op_val, e_op_val);
      chk("req_rdy", req_rdy, e_req_rdy);
      if (e_op_val) begin
        chk("cop_op_A", cop_op_A, ea);
        chk("cop_op_B", cop_op_B, eb);
      end
      chk("resp_val", resp_val, e_resp_val);
      chk("cop_res_rdy", cop_res_rdy, e_res_rdy);
      if (|e_resp_val) chk("resp_bits", resp_bits, cop_res_bits);
      chk("err_orphan", err_orphan, m_orphan);
`ifdef GCD_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("stat_grants", stat_grants[i*16 +: 16], m_grants[i]);
      chk("stat_stall", stat_stall, m_stall);
`endif
    end else begin
      chk("rst_cop_op_val", cop_op_val, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_val", resp_val, 0);
      chk("rst_cop_res_rdy", cop_res_rdy, 0);
    end
    @(posedge clk);
    if (!reset) begin
      m_tags.delete();
      m_cop.delete();
      m_ptr = 0;
      m_orphan = 0;
      m_stall = 0;
      for (int i = 0; i < NREQ; i++) m_grants[i] = 0;
    end else begin
      if (cop_res_val && empty) m_orphan = 1;
      if (pop) begin
        void'(m_tags.pop_front());
        if (m_cop.size() > 0) void'(m_cop.pop_front());
      end
      if (fire) begin
        m_tags.push_back(g);
        m_cop.push_back(int'(gcd(32'(ea), 32'(eb))));
        m_ptr = (g + 1) % NREQ;
        if (m_grants[g] < 65535) m_grants[g]++;
      end
      if (any && !fire && m_stall < 65535) m_stall++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    req_val = '0;
    cycle();
    cycle();
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic set_ops(input int r, input int a, input int b);
    req_bits_A[r*W +: W] = W'(a);
    req_bits_B[r*W +: W] = W'(b);
  endtask

  task automatic chk_dlv(input string tag, input int idx, input int own, input int val);
    if (dlv_own.size() > idx) begin
      chk({tag, "_owner"}, dlv_own[idx], own);
      chk({tag, "_value"}, dlv_val[idx], val);
    end else begin
      chk({tag, "_missing"}, dlv_own.size(), idx + 1);
    end
  endtask

  initial begin
    int exp_own[5];
    int exp_val[5];
    reset = 1'b0;
    req_val = '0;
    req_bits_A = '0;
    req_bits_B = '0;
    resp_rdy = '0;
    cop_op_rdy = 1'b0;
    cop_res_val = 1'b0;
    cop_res_bits = '0;
    cop_en = 1'b0;
    inject = 1'b0;
    m_ptr = 0;
    m_orphan = 0;
    m_stall = 0;
    for (int i = 0; i < NREQ; i++) m_grants[i] = 0;

    // 1: single requester
    do_reset();
    set_ops(0, 27, 15);
    resp_rdy = '1;
    cop_op_rdy = 1'b1;
    cop_en = 1'b1;
    req_val = 4'b0001;
    cycle();
    req_val = '0;
    repeat (4) cycle();
    chk("t1_count", dlv_own.size(), 1);
    chk_dlv("t1", 0, 0, 3);

    // 2: all four valid from rr_ptr=0
    do_reset();
    set_ops(0, 21, 49);
    set_ops(1, 25, 30);
    set_ops(2, 250, 190);
    set_ops(3, 96, 4096);
    req_val = '1;
    for (int c = 0; c < 20 && fire_log.size() < 5; c++) cycle();
    req_val = '0;
    repeat (8) cycle();
    exp_own = '{0, 1, 2, 3, 0};
    exp_val = '{7, 5, 10, 32, 7};
    chk("t2_fires", fire_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (fire_log.size() > i) chk("t2_fire_order", fire_log[i], exp_own[i]);
      chk_dlv("t2", i, exp_own[i], exp_val[i]);
    end

    // 3: FIFO fills while results are blocked; no bypass on the pop cycle
    do_reset();
    resp_rdy = '0;
    req_val = '1;
    for (int c = 0; c < 20 && fire_log.size() < 4; c++) cycle();
    chk("t3_fires", fire_log.size(), 4);
    chk("t3_full_blocks", req_rdy, 0);
    resp_rdy = '1;
    #1;
    chk("t3_pop_rdy", cop_res_rdy, 1);
    chk("t3_no_bypass", req_rdy, 0);
    cycle();
    chk("t3_refire", |req_rdy, 1);
    req_val = '0;
    repeat (10) cycle();

    // 4: result backpressure for 10 cycles, then delivered once
    do_reset();
    resp_rdy = '0;
    req_val = 4'b0010;
    cycle();
    req_val = '0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("t4_held_rdy", cop_res_rdy, 0);
      chk("t4_held_val", resp_val, 4'b0010);
    end
    resp_rdy = '1;
    repeat (5) cycle();
    chk("t4_count", dlv_own.size(), 1);
    chk_dlv("t4", 0, 1, 5);

    // 5: reset with two requests outstanding
    do_reset();
    resp_rdy = '0;
    req_val = 4'b0011;
    cycle();
    cycle();
    req_val = '0;
    chk("t5_outstanding", m_tags.size(), 2);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    clear_logs();
    req_val = '1;
    #1;
    chk("t5_ptr_zero", req_rdy, 4'b0001);
    set_ops(2, 6993, 999);
    req_val = 4'b0100;
    resp_rdy = '1;
    cycle();
    req_val = '0;
    repeat (5) cycle();
    chk("t5_count", dlv_own.size(), 1);
    chk_dlv("t5", 0, 2, 999);
    chk("t5_no_orphan", err_orphan, 0);

`ifdef GCD_ARB_STATS_EN
    // 6: five fires from requester 1
    do_reset();
    set_ops(1, 25, 30);
    req_val = 4'b0010;
    repeat (5) cycle();
    req_val = '0;
    cycle();
    chk("t6_grants0", stat_grants[0 +: 16], 0);
    chk("t6_grants1", stat_grants[16 +: 16], 5);
    chk("t6_grants2", stat_grants[32 +: 16], 0);
    chk("t6_grants3", stat_grants[48 +: 16], 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req_val = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) set_ops(r, $urandom_range(1, 4095), $urandom_range(1, 4095));
      resp_rdy = NREQ'($urandom);
      cop_op_rdy = ($urandom_range(0, 3) != 0);
      cop_en = ($urandom_range(0, 9) < 7);
      cycle();
    end
    req_val = '0;
    resp_rdy = '1;
    cop_op_rdy = 1'b1;
    cop_en = 1'b1;
    repeat (10) cycle();

    // Orphan result with an empty tag FIFO sets the sticky flag
    chk("orphan_pre", err_orphan, 0);
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    cycle();
    chk("orphan_set", err_orphan, 1);
    cycle();
    chk("orphan_sticky", err_orphan, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
